riot_bus_initiator: RTL and testbench
=====================================

Name: riot_bus_initiator

Overview:
- Host-side initiator for the 6502-style RIOT/TIA register bus.
- Lets a debug/savestate agent issue single or burst reads and writes to a PHI2-clock-enabled responder: RAM, port, DDR, timer and interrupt registers.
- Arbitrates the bus from the CPU with a req/gnt handshake, generates chip selects from a decoded address, then returns read data over a valid/ready response channel.

Parameters:
- RIOT_BASE, 16'h0480, base address of the RIOT register window; A[6:0] is passed through.
- RAM_BASE, 16'h0080, base of the 128-byte RIOT RAM window (RS_n low).
- GNT_TIMEOUT, 255, clk cycles to wait for bus_gnt before aborting with error.
- MAX_BURST, 16, maximum burst length (req_len range 1..MAX_BURST).

Ports:
- clk  in  1  system clock
- res_n  in  1  asynchronous active-low reset
- ce  in  1  PHI2 clock enable; the bus transfers on ce-qualified clk edges
- req_valid  in  1  command valid
- req_ready  out  1  command accepted when valid&ready
- req_rw_n  in  1  1=read, 0=write
- req_addr  in  16  start address
- req_len  in  5  beats, 1..MAX_BURST; 0 is treated as 1
- req_wdata  in  8  write data for the current beat, sampled at each write beat
- wdata_req  out  1  pulse: req_wdata consumed, present the next byte
- rsp_valid  out  1  response beat valid
- rsp_ready  in  1  response accepted
- rsp_data  out  8  read data; 8'h00 for writes
- rsp_last  out  1  final beat of the burst
- rsp_err  out  1  grant timeout or address outside both windows
- bus_req  out  1  request to halt the CPU and own the bus
- bus_gnt  in  1  CPU halted, bus owned
- bus_addr  out  7  responder addr[6:0]
- bus_rw_n  out  1  responder RW_n
- bus_dout  out  8  responder d_in
- bus_din  in  8  responder d_out
- bus_cs1  out  1  CS1
- bus_cs2_n  out  1  CS2_n
- bus_rs_n  out  1  RS_n

Behaviour:
- Reset values (async on res_n low):
  - req_ready=0, rsp_valid=0, rsp_data=0, rsp_last=0, rsp_err=0, wdata_req=0.
  - bus_req=0, bus_rw_n=1, bus_cs1=0, bus_cs2_n=1, bus_rs_n=1, bus_addr=0, bus_dout=0.
  - State=IDLE, all counters 0.
- IDLE:
  - req_ready=1.
  - On valid&ready: latch rw, addr, len (0→1), beat count=0; go DECODE.
- DECODE (1 clk):
  - addr in [RAM_BASE, RAM_BASE+127] → rs_n=0.
  - addr in [RIOT_BASE, RIOT_BASE+127] → rs_n=1.
  - Otherwise → ERR.
  - Valid window → REQ with bus_req=1.
- REQ:
  - Hold bus_req.
  - bus_gnt sampled high → SETUP.
  - Timeout counter reaches GNT_TIMEOUT → ERR with bus_req dropped.
- SETUP:
  - Drive bus_addr=addr[6:0], rw_n, cs1=1, cs2_n=0, rs_n; for writes, bus_dout=req_wdata.
  - Wait for ce. On the ce clk the responder latches the write (or registers d_out for a read).
  - Writes: pulse wdata_req for this clk.
  - Next state: CAPTURE.
- CAPTURE (1 clk):
  - Deassert cs1/cs2_n.
  - Read: rsp_data<=bus_din.
  - Write: rsp_data<=0.
  - Next state: RESP.
- RESP:
  - rsp_valid=1; rsp_last=(beat==len-1).
  - On rsp_ready: beat+1. If last → RELEASE; else SETUP with addr+1.
  - Address increments only in bits [6:0], wrapping within the 128-byte window (7F→00).
  - rsp_valid stays high until accepted; the next bus beat does not start while stalled.
- RELEASE: drop bus_req → IDLE. Takes one clk; bus_gnt is not awaited low.
- ERR:
  - rsp_valid=1, rsp_err=1, rsp_last=1, rsp_data=0.
  - On rsp_ready → IDLE. Remaining beats are discarded.
- Chip selects are asserted only in SETUP. This guarantees exactly one ce-qualified selected cycle per beat, so destructive reads (interrupt flag clear, timer rollover clear) occur exactly once.
- If bus_gnt drops mid-burst: finish the current beat, then return to REQ before the next SETUP; the timeout counter restarts.
- If reset is asserted mid-transfer: all outputs return to reset values immediately and the transaction is lost.
- req_ready is low in every state except IDLE.

Decomposition:
- Shared package riot_bus_pkg holds:
  - state enum (IDLE, DECODE, REQ, SETUP, CAPTURE, RESP, RELEASE, ERR);
  - window-size constant 7'h7F;
  - beat-count width localparam.
- One sub-module, riot_addr_decode: combinational window match producing hit, rs_n and err.

Test Plan:
- Single write, addr 16'h0080, wdata 8'h5A, gnt after 3 clk, ce every 4 clk → one selected cycle with rs_n=0, bus_rw_n=0, bus_dout=5A; rsp_last=1, rsp_err=0.
- Single read, addr 16'h0482 (responder returns 8'hC3) → rsp_data=C3 one clk after the ce cycle; cs1 high for exactly one ce.
- Burst read, len=4, start 16'h00FE → bus_addr sequence 7E, 7F, 00, 01; four beats, last beat rsp_last=1.
- rsp_ready held low 10 clk on beat 2 of a len=3 read → rsp_valid held with stable data; no SETUP and no cs assertion during the stall.
- bus_gnt never asserted, GNT_TIMEOUT=8 → after 8 clk bus_req drops; one beat with rsp_err=1, rsp_last=1.
- Address 16'h2000 → ERR without bus_req; res_n pulsed during SETUP → cs1=0, bus_req=0 asynchronously, req_ready=1 after release.

Source files
------------

// File: rtl/riot_bus_pkg.sv
// Shared types and constants for the RIOT/TIA bus initiator.
package riot_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        REQ,
        SETUP,
        CAPTURE,
        RESP,
        RELEASE,
        ERR
    } state_t;

    localparam logic [6:0] WIN_MASK = 7'h7F;
    localparam int         BEAT_W   = 5;

    // A zero length means one beat; anything past the burst limit is clipped to it.
    function automatic logic [BEAT_W-1:0] eff_len(input logic [BEAT_W-1:0] len,
                                                  input logic [BEAT_W-1:0] max_len);
        if (len == '0)
            return BEAT_W'(1);
        else if (len > max_len)
            return max_len;
        else
            return len;
    endfunction

endpackage

// File: rtl/riot_addr_decode.sv
// Window match for a 16-bit start address: RAM window selects RS_n low, register window RS_n high.
module riot_addr_decode
    import riot_bus_pkg::*;
#(
    parameter logic [15:0] RIOT_BASE = 16'h0480,
    parameter logic [15:0] RAM_BASE  = 16'h0080
) (
    input  logic [15:0] addr,
    output logic        hit,
    output logic        rs_n,
    output logic        err
);

    logic hit_ram;
    logic hit_riot;

    // 17-bit compares so a window placed at the top of the map cannot wrap.
    assign hit_ram  = ({1'b0, addr} >= {1'b0, RAM_BASE}) &&
                      ({1'b0, addr} <= ({1'b0, RAM_BASE} + 17'(WIN_MASK)));
    assign hit_riot = ({1'b0, addr} >= {1'b0, RIOT_BASE}) &&
                      ({1'b0, addr} <= ({1'b0, RIOT_BASE} + 17'(WIN_MASK)));

    assign hit  = hit_ram | hit_riot;
    assign rs_n = ~hit_ram;
    assign err  = ~hit;

endmodule

// File: rtl/riot_bus_initiator.sv
// Debug/savestate initiator: owns the CPU bus via req/gnt and runs single or burst beats to the RIOT.
// States: IDLE accept | DECODE window | REQ await gnt | SETUP select until ce | CAPTURE latch | RESP hand back | RELEASE drop req | ERR error beat
module riot_bus_initiator
    import riot_bus_pkg::*;
#(
    parameter logic [15:0] RIOT_BASE   = 16'h0480,
    parameter logic [15:0] RAM_BASE    = 16'h0080,
    parameter int          GNT_TIMEOUT = 255,
    parameter int          MAX_BURST   = 16
) (
    input  logic        clk,
    input  logic        res_n,
    input  logic        ce,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_rw_n,
    input  logic [15:0] req_addr,
    input  logic [4:0]  req_len,
    input  logic [7:0]  req_wdata,
    output logic        wdata_req,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [7:0]  rsp_data,
    output logic        rsp_last,
    output logic        rsp_err,
    output logic        bus_req,
    input  logic        bus_gnt,
    output logic [6:0]  bus_addr,
    output logic        bus_rw_n,
    output logic [7:0]  bus_dout,
    input  logic [7:0]  bus_din,
    output logic        bus_cs1,
    output logic        bus_cs2_n,
    output logic        bus_rs_n
);

    localparam int               TMO_W    = (GNT_TIMEOUT > 1) ? $clog2(GNT_TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(GNT_TIMEOUT - 1);

    state_t            state;
    state_t            state_d;
    logic              rw_q;
    logic [15:0]       addr_q;
    logic [BEAT_W-1:0] len_q;
    logic [BEAT_W-1:0] beat_q;
    logic [TMO_W-1:0]  tmo_q;
    logic [7:0]        data_q;
    logic              ready_q;
    logic              rs_n_q;
    logic              dec_hit;
    logic              dec_rs_n;
    logic              dec_err;
    logic              accept;
    logic              last_beat;
    logic              in_setup;

    riot_addr_decode #(
        .RIOT_BASE (RIOT_BASE),
        .RAM_BASE  (RAM_BASE)
    ) u_addr_decode (
        .addr (addr_q),
        .hit  (dec_hit),
        .rs_n (dec_rs_n),
        .err  (dec_err)
    );

    assign accept    = (state == IDLE) && ready_q && req_valid;
    assign last_beat = (beat_q == (len_q - 1'b1));
    assign in_setup  = (state == SETUP);

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n)
            state <= IDLE;
        else
            state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (accept) state_d = DECODE;
            DECODE:  state_d = (dec_hit && !dec_err) ? REQ : ERR;
            REQ: begin
                if (bus_gnt)
                    state_d = SETUP;
                else if (tmo_q == '0)
                    state_d = ERR;
            end
            SETUP:   if (ce) state_d = CAPTURE;
            CAPTURE: state_d = RESP;
            // A lost grant is only noticed between beats, never inside one.
            RESP: begin
                if (rsp_ready) begin
                    if (last_beat)
                        state_d = RELEASE;
                    else
                        state_d = bus_gnt ? SETUP : REQ;
                end
            end
            RELEASE: state_d = IDLE;
            ERR:     if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            rw_q    <= 1'b1;
            addr_q  <= '0;
            len_q   <= '0;
            beat_q  <= '0;
            tmo_q   <= '0;
            data_q  <= '0;
            ready_q <= 1'b0;
            rs_n_q  <= 1'b1;
        end else begin
            ready_q <= (state_d == IDLE);
            case (state)
                IDLE: begin
                    if (accept) begin
                        rw_q   <= req_rw_n;
                        addr_q <= req_addr;
                        len_q  <= eff_len(req_len, BEAT_W'(MAX_BURST));
                        beat_q <= '0;
                    end
                end
                DECODE: begin
                    rs_n_q <= dec_rs_n;
                    tmo_q  <= TMO_LOAD;
                end
                REQ: begin
                    if (!bus_gnt && tmo_q != '0)
                        tmo_q <= tmo_q - 1'b1;
                end
                CAPTURE: data_q <= rw_q ? bus_din : 8'h00;
                RESP: begin
                    if (rsp_ready) begin
                        beat_q      <= beat_q + 1'b1;
                        addr_q[6:0] <= (addr_q[6:0] + 7'd1) & WIN_MASK;
                        tmo_q       <= TMO_LOAD;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready = ready_q;
    assign wdata_req = in_setup && ce && !rw_q;
    assign rsp_valid = (state == RESP) || (state == ERR);
    assign rsp_err   = (state == ERR);
    assign rsp_last  = (state == ERR) || ((state == RESP) && last_beat);
    assign rsp_data  = (state == RESP) ? data_q : 8'h00;
    assign bus_req   = (state == REQ) || (state == SETUP) || (state == CAPTURE) || (state == RESP);
    assign bus_addr  = addr_q[6:0];
    assign bus_rw_n  = in_setup ? rw_q : 1'b1;
    assign bus_dout  = (in_setup && !rw_q) ? req_wdata : 8'h00;
    assign bus_cs1   = in_setup;
    assign bus_cs2_n = ~in_setup;
    assign bus_rs_n  = in_setup ? rs_n_q : 1'b1;

endmodule

// File: tb/tb_riot_bus_initiator.sv
// Scoreboard bench: a memory-model responder plus a reference model of beats, addresses and data.
module tb_riot_bus_initiator;

    logic        clk       = 1'b0;
    logic        res_n     = 1'b0;
    logic        ce        = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_rw_n  = 1'b1;
    logic [15:0] req_addr  = '0;
    logic [4:0]  req_len   = '0;
    logic [7:0]  req_wdata = '0;
    logic        rsp_ready = 1'b1;
    logic        bus_gnt   = 1'b0;
    logic [7:0]  bus_din   = '0;
    logic        req_ready, wdata_req, rsp_valid, rsp_last, rsp_err;
    logic        bus_req, bus_rw_n, bus_cs1, bus_cs2_n, bus_rs_n;
    logic [7:0]  rsp_data, bus_dout;
    logic [6:0]  bus_addr;

    riot_bus_initiator #(.GNT_TIMEOUT(8)) dut (
        .clk(clk), .res_n(res_n), .ce(ce),
        .req_valid(req_valid), .req_ready(req_ready), .req_rw_n(req_rw_n),
        .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata), .wdata_req(wdata_req),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_last(rsp_last), .rsp_err(rsp_err),
        .bus_req(bus_req), .bus_gnt(bus_gnt), .bus_addr(bus_addr), .bus_rw_n(bus_rw_n),
        .bus_dout(bus_dout), .bus_din(bus_din), .bus_cs1(bus_cs1), .bus_cs2_n(bus_cs2_n),
        .bus_rs_n(bus_rs_n)
    );

    always #5 clk = ~clk;

    typedef struct { logic [7:0] data; logic last; logic err; } rsp_t;
    typedef struct { logic rw_n; logic rs_n; logic [6:0] addr; logic [7:0] dout; } bus_t;

    rsp_t       rsp_q[$];
    bus_t       bus_q[$];
    logic [7:0] resp_mem[256];
    logic [7:0] ref_mem[256];
    int         tests = 0;
    int         fails = 0;
    int         gnt_delay = 3;
    bit         gnt_en = 1'b1;
    bit         gnt_flaky = 1'b0;
    int         rdy_mode = 0;
    int         beat_idx = 0;
    int         stall_cnt = 0;
    int         stall_seen = 0;
    int         run = 0;
    int         last_run = 0;
    bit         req_seen = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        int n = 0;
        forever begin
            @(posedge clk); #1;
            ce = (n % 4 == 3);
            n++;
        end
    end

    initial begin
        int w = 0;
        forever begin
            @(posedge clk); #1;
            if (!bus_req || !gnt_en) begin
                bus_gnt = 1'b0;
                w = 0;
            end else if (!bus_gnt) begin
                if (w >= gnt_delay) bus_gnt = 1'b1;
                else w++;
            end else if (gnt_flaky && $urandom_range(7) == 0) begin
                bus_gnt = 1'b0;
                w = 0;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0: rsp_ready = 1'b1;
                1: rsp_ready = ($urandom_range(3) != 0);
                default: begin
                    if (beat_idx == 1 && rsp_valid && stall_cnt < 10) begin
                        rsp_ready = 1'b0;
                        stall_cnt++;
                    end else begin
                        rsp_ready = 1'b1;
                    end
                end
            endcase
        end
    end

    // Response monitor: pops the scoreboard on every accepted beat.
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            if (res_n && rsp_valid) begin
                chk("cs_idle_while_rsp", bus_cs1, 1'b0);
                if (rsp_ready) begin
                    if (rsp_q.size() == 0) begin
                        chk("rsp_expected", rsp_q.size(), 1);
                    end else begin
                        e = rsp_q.pop_front();
                        chk("rsp_data", rsp_data, e.data);
                        chk("rsp_last", rsp_last, e.last);
                        chk("rsp_err", rsp_err, e.err);
                    end
                    beat_idx++;
                end else begin
                    stall_seen++;
                    if (rsp_q.size() != 0) chk("stall_data", rsp_data, rsp_q[0].data);
                end
            end
        end
    end

    // Responder: one memory cell per selected ce cycle, plus bus-side scoreboard.
    initial begin
        bus_t       b;
        logic [7:0] idx;
        forever begin
            @(negedge clk);
            if (res_n && ce && bus_cs1 && !bus_cs2_n) begin
                idx = {bus_rs_n, bus_addr};
                if (bus_q.size() == 0) begin
                    chk("bus_select_expected", bus_q.size(), 1);
                end else begin
                    b = bus_q.pop_front();
                    chk("bus_rw_n", bus_rw_n, b.rw_n);
                    chk("bus_rs_n", bus_rs_n, b.rs_n);
                    chk("bus_addr", bus_addr, b.addr);
                    if (!b.rw_n) chk("bus_dout", bus_dout, b.dout);
                end
                if (!bus_rw_n) resp_mem[idx] = bus_dout;
                else bus_din = resp_mem[idx];
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (bus_req) begin
                run++;
                req_seen = 1'b1;
            end else begin
                if (run != 0) last_run = run;
                run = 0;
            end
        end
    end

    task automatic send(input bit rw, input logic [15:0] addr, input logic [4:0] len,
                        input logic [7:0] wd);
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_rw_n  = rw;
        req_addr  = addr;
        req_len   = len;
        req_wdata = wd;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (req_ready) break;
        end
        chk("req_accepted", req_ready, 1'b1);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic issue(input bit rw, input logic [15:0] addr, input logic [4:0] len,
                         input bit granted, input logic [7:0] wd0);
        int         n;
        int         a;
        int         key;
        int         widx;
        bit         adv;
        bit         in_ram;
        bit         in_riot;
        logic [7:0] wbuf[16];
        rsp_t       r;
        bus_t       b;
        n = (len == 0) ? 1 : ((len > 16) ? 16 : int'(len));
        in_ram  = (addr >= 16'h0080) && (addr <= 16'h00FF);
        in_riot = (addr >= 16'h0480) && (addr <= 16'h04FF);
        beat_idx = 0;
        stall_cnt = 0;
        stall_seen = 0;
        wbuf[0] = wd0;
        for (int i = 1; i < 16; i++) wbuf[i] = 8'($urandom);
        if (!(in_ram || in_riot) || !granted) begin
            r.data = 8'h00; r.last = 1'b1; r.err = 1'b1;
            rsp_q.push_back(r);
        end else begin
            for (int i = 0; i < n; i++) begin
                a   = (int'(addr[6:0]) + i) % 128;
                key = in_ram ? a : 128 + a;
                r.last = (i == n - 1);
                r.err  = 1'b0;
                b.rs_n = !in_ram;
                b.addr = 7'(a);
                b.rw_n = rw;
                if (rw) begin
                    r.data = ref_mem[key];
                    b.dout = 8'h00;
                end else begin
                    ref_mem[key] = wbuf[i];
                    r.data = 8'h00;
                    b.dout = wbuf[i];
                end
                rsp_q.push_back(r);
                bus_q.push_back(b);
            end
        end
        send(rw, addr, len, wbuf[0]);
        widx = 0;
        for (int c = 0; c < 3000 && rsp_q.size() != 0; c++) begin
            @(negedge clk);
            adv = wdata_req;
            @(posedge clk); #1;
            if (adv && widx < n - 1) begin
                widx++;
                req_wdata = wbuf[widx];
            end
        end
        chk("rsp_drained", rsp_q.size(), 0);
        chk("bus_drained", bus_q.size(), 0);
        rsp_q.delete();
        bus_q.delete();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: time limit reached, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  v;
        logic [15:0] ad;
        int          cat;
        for (int i = 0; i < 256; i++) begin
            v = 8'($urandom);
            resp_mem[i] = v;
            ref_mem[i]  = v;
        end
        resp_mem[130] = 8'hC3;
        ref_mem[130]  = 8'hC3;

        #1;
        chk("reset_ctrl", {req_ready, rsp_valid, rsp_last, rsp_err, wdata_req, bus_req,
                           bus_rw_n, bus_cs1, bus_cs2_n, bus_rs_n}, 10'b00_0000_1011);
        chk("reset_data", {rsp_data, bus_dout, bus_addr}, 0);
        #21 res_n = 1'b1;
        repeat (2) @(posedge clk);

        gnt_delay = 3;
        issue(1'b0, 16'h0080, 5'd1, 1'b1, 8'h5A);
        issue(1'b1, 16'h0482, 5'd1, 1'b1, 8'h00);
        issue(1'b1, 16'h00FE, 5'd4, 1'b1, 8'h00);
        issue(1'b1, 16'h0080, 5'd1, 1'b1, 8'h00);

        rdy_mode = 2;
        issue(1'b1, 16'h0490, 5'd3, 1'b1, 8'h00);
        chk("stall_cycles", stall_seen, 10);
        rdy_mode = 0;

        gnt_en = 1'b0;
        issue(1'b1, 16'h0090, 5'd3, 1'b0, 8'h00);
        chk("timeout_req_cycles", last_run, 8);
        gnt_en = 1'b1;

        req_seen = 1'b0;
        issue(1'b0, 16'h2000, 5'd2, 1'b1, 8'h11);
        chk("bad_addr_no_bus_req", req_seen, 1'b0);
        issue(1'b1, 16'h0500, 5'd0, 1'b1, 8'h00);

        send(1'b1, 16'h0485, 5'd1, 8'h00);
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (bus_cs1 && !ce) break;
        end
        chk("reached_setup", bus_cs1, 1'b1);
        res_n = 1'b0;
        #1;
        chk("reset_mid_setup", {bus_cs1, bus_req, req_ready, rsp_valid}, 4'b0000);
        repeat (2) @(negedge clk);
        res_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_reset", req_ready, 1'b1);

        rdy_mode  = 1;
        gnt_flaky = 1'b1;
        for (int k = 0; k < 40; k++) begin
            cat = $urandom_range(9);
            if (cat < 4)      ad = 16'h0080 + 16'($urandom_range(127));
            else if (cat < 8) ad = 16'h0480 + 16'($urandom_range(127));
            else              ad = 16'($urandom_range(16'hFFFF));
            gnt_delay = $urandom_range(3);
            issue(1'($urandom_range(1)), ad, 5'($urandom_range(16)), 1'b1, 8'($urandom));
        end
        for (int k = 0; k < 16; k++) begin
            ad = (k < 8) ? (16'h0080 + 16'(k * 16)) : (16'h0480 + 16'((k - 8) * 16));
            issue(1'b1, ad, 5'd16, 1'b1, 8'h00);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
